// File: rtl/io_port.sv
// Bus-attached I/O port: RX FIFO from an external producer, TX FIFO toward an external consumer.
// Optional status register and sticky error flags are enabled with `define IO_STATUS_EN.
module io_port #(
    parameter int word_width      = 16,
    parameter int fifo_depth_log2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] bus_in,
    output logic [word_width-1:0] bus_out,
    input  logic                  io_oe,
    input  logic                  io_we,
    input  logic                  io_sel,
    input  logic [word_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [word_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int depth = 1 << fifo_depth_log2;

    typedef logic [fifo_depth_log2-1:0] ptr_t;
    typedef logic [fifo_depth_log2:0]   cnt_t;

    localparam cnt_t full_count = cnt_t'(depth);

    logic [word_width-1:0] rx_mem [depth];
    logic [word_width-1:0] tx_mem [depth];

    ptr_t rx_rd, rx_wr, tx_rd, tx_wr;
    cnt_t rx_count, tx_count;

    logic rx_empty, rx_full, tx_empty, tx_full;
    logic status_sel;
    logic data_read;
    logic rx_push, rx_pop, tx_push, tx_pop;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == full_count);
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == full_count);

`ifdef IO_STATUS_EN
    logic rx_underflow, tx_overflow;
    logic rx_under_evt, tx_over_evt, status_clr;
    logic [word_width-1:0] status_word;

    assign status_sel   = io_sel;
    assign status_clr   = rst && io_oe && io_sel;
    assign rx_under_evt = data_read && rx_empty;
    assign tx_over_evt  = rst && io_we && tx_full;

    always_comb begin
        status_word       = '0;
        status_word[15]   = rx_underflow;
        status_word[14]   = tx_overflow;
        status_word[7:4]  = 4'(tx_count);
        status_word[3:0]  = 4'(rx_count);
    end

    // A flag event in the same cycle as the clearing status read keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_underflow <= 1'b0;
            tx_overflow  <= 1'b0;
        end else begin
            rx_underflow <= rx_under_evt || (rx_underflow && !status_clr);
            tx_overflow  <= tx_over_evt  || (tx_overflow  && !status_clr);
        end
    end
`else
    logic sel_unused;

    assign sel_unused = io_sel;
    assign status_sel = 1'b0;
`endif

    assign in_ready  = rst && !rx_full;
    assign out_valid = rst && !tx_empty;

    assign data_read = rst && io_oe && !status_sel;
    assign rx_push   = in_valid && in_ready;
    assign rx_pop    = data_read && !rx_empty;
    assign tx_push   = rst && io_we && !tx_full;
    assign tx_pop    = out_valid && out_ready;

    assign out_data = out_valid ? tx_mem[tx_rd] : '0;

    always_comb begin
        bus_out = '0;
        if (rst && io_oe) begin
`ifdef IO_STATUS_EN
            if (status_sel)
                bus_out = status_word;
            else if (!rx_empty)
                bus_out = rx_mem[rx_rd];
`else
            if (!rx_empty)
                bus_out = rx_mem[rx_rd];
`endif
        end
    end

    // Storage needs no reset: counts gate every read of stale entries.
    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr] <= in_data;
        if (tx_push)
            tx_mem[tx_wr] <= bus_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_rd    <= '0;
            rx_wr    <= '0;
            rx_count <= '0;
            tx_rd    <= '0;
            tx_wr    <= '0;
            tx_count <= '0;
        end else begin
            if (rx_push)
                rx_wr <= rx_wr + ptr_t'(1);
            if (rx_pop)
                rx_rd <= rx_rd + ptr_t'(1);
            rx_count <= rx_count + cnt_t'(rx_push) - cnt_t'(rx_pop);

            if (tx_push)
                tx_wr <= tx_wr + ptr_t'(1);
            if (tx_pop)
                tx_rd <= tx_rd + ptr_t'(1);
            tx_count <= tx_count + cnt_t'(tx_push) - cnt_t'(tx_pop);
        end
    end

endmodule

// File: tb/tb_io_port.sv
// Directed testbench for io_port with hand-computed expectations.
// Status-register checks are compiled only when IO_STATUS_EN is defined.
module tb_io_port;

    logic        clk;
    logic        rst;
    logic [15:0] bus_in;
    logic [15:0] bus_out;
    logic        io_oe;
    logic        io_we;
    logic        io_sel;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int check_count = 0;
    int pass_count  = 0;

    io_port #(
        .word_width     (16),
        .fifo_depth_log2(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_in   (bus_in),
        .bus_out  (bus_out),
        .io_oe    (io_oe),
        .io_we    (io_we),
        .io_sel   (io_sel),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic oe, input logic we, input logic sel,
                                 input logic [15:0] bin, input logic iv,
                                 input logic [15:0] idata, input logic ordy);
        io_oe     = oe;
        io_we     = we;
        io_sel    = sel;
        bus_in    = bin;
        in_valid  = iv;
        in_data   = idata;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h5555, 1'b0);
        tick();
        tick();
        checkOutput("reset in_ready", 16'(in_ready), 16'h0);
        checkOutput("reset out_valid", 16'(out_valid), 16'h0);
        checkOutput("reset out_data", out_data, 16'h0);
        checkOutput("reset bus_out", bus_out, 16'h0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("post-reset in_ready", 16'(in_ready), 16'h1);

        $display("[TB] RX order and underflow");
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hABCD, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("rx read 1", bus_out, 16'h1234);
        tick();
        checkOutput("rx read 2", bus_out, 16'hABCD);
        tick();
        checkOutput("rx empty read", bus_out, 16'h0000);
        tick();
`ifdef IO_STATUS_EN
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("status underflow", bus_out, 16'h8000);
        tick();
        checkOutput("status cleared", bus_out, 16'h0000);
        tick();
`endif

        $display("[TB] RX full backpressure");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1,
                          (i < 4) ? 16'(16'h10 + i) : 16'h14, 1'b0);
            checkOutput($sformatf("rx fill ready %0d", i), 16'(in_ready),
                        (i < 4) ? 16'h1 : 16'h0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h14, 1'b0);
        checkOutput("rx full pop", bus_out, 16'h0010);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h14, 1'b0);
        checkOutput("rx ready after pop", 16'(in_ready), 16'h1);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
            checkOutput($sformatf("rx drain %0d", i), bus_out, 16'(16'h11 + i));
            tick();
        end

        $display("[TB] TX overflow and drain");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'(i + 1), 1'b0, 16'h0, 1'b0);
            tick();
            checkOutput($sformatf("tx valid %0d", i), 16'(out_valid), 16'h1);
            checkOutput($sformatf("tx head %0d", i), out_data, 16'h0001);
        end
`ifdef IO_STATUS_EN
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("status overflow", bus_out, 16'h4040);
        tick();
`endif
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
            checkOutput($sformatf("tx drain %0d", i), out_data, 16'(i + 1));
            tick();
        end
        checkOutput("tx empty valid", 16'(out_valid), 16'h0);
        checkOutput("tx empty data", out_data, 16'h0);

        $display("[TB] TX push while empty with out_ready");
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h00FF, 1'b0, 16'h0, 1'b1);
        checkOutput("tx no same-cycle valid", 16'(out_valid), 16'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        checkOutput("tx ff valid", 16'(out_valid), 16'h1);
        checkOutput("tx ff data", out_data, 16'h00FF);
        tick();
        checkOutput("tx ff popped", 16'(out_valid), 16'h0);

        $display("[TB] Reset with buffered words");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, (i < 2), 1'b0, 16'(16'hB0 + i), 1'b1,
                          16'(16'hA0 + i), 1'b0);
            tick();
        end
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h7777, 1'b1);
        checkOutput("mid reset in_ready", 16'(in_ready), 16'h0);
        checkOutput("mid reset out_valid", 16'(out_valid), 16'h0);
        checkOutput("mid reset out_data", out_data, 16'h0);
        checkOutput("mid reset bus_out", bus_out, 16'h0);
        tick();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("after reset in_ready", 16'(in_ready), 16'h1);
        checkOutput("after reset out_valid", 16'(out_valid), 16'h0);
`ifdef IO_STATUS_EN
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("after reset status", bus_out, 16'h0000);
        tick();
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("after reset read", bus_out, 16'h0000);
        tick();
`ifdef IO_STATUS_EN
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("underflow after reset", bus_out, 16'h8000);
        tick();
`endif

        $display("[TB] Status read does not pop");
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0042, 1'b0);
        tick();
`ifdef IO_STATUS_EN
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("status rx count", bus_out, 16'h0001);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("data after status", bus_out, 16'h0042);
        tick();
`else
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("sel ignored read", bus_out, 16'h0042);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("sel ignored popped", bus_out, 16'h0000);
        tick();
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
